// File: rtl/spi_cmd_ram_pkg.sv
// Shared opcodes, control-state encodings and helpers for the SPI command RAM.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // bit0 = write address held, bit1 = read address held
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WADDR = 2'b01,
    ST_RADDR = 2'b10,
    ST_BOTH  = 2'b11
  } state_t;

  function automatic logic addr_in_range(input logic [7:0] a, input int unsigned depth);
    return 32'(a) < depth;
  endfunction

endpackage

// File: rtl/spi_cmd_ram_if.sv
// Command/response bundle between the SPI slave (master side) and the command RAM.
interface spi_cmd_ram_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       err;

  modport master (output din, rx_valid, input dout, tx_valid, err);
  modport slave  (input din, rx_valid, output dout, tx_valid, err);
endinterface

// File: rtl/spi_cmd_ram_ram_sp.sv
// Single-port byte RAM: synchronous write, registered read, no reset on storage.
module ram_sp #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_cmd_ram.sv
// Decodes SPI command words into address-latch / write / read operations on a byte RAM,
// with range/protocol checking and optional address post-increment.
module spi_cmd_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC  = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_cmd_ram_if.slave bus
);

  state_t                 state;
  logic                   rx_valid_q;
  logic                   accept;
  logic                   wr_ok, rd_ok, in_range;
  logic                   we, re;
  logic                   tx_q, err_q, dout_clr;
  logic [1:0]             op;
  logic [7:0]             payload, rdata;
  logic [ADDR_SIZE-1:0]   wr_addr, rd_addr, ram_addr;

  function automatic logic [ADDR_SIZE-1:0] inc_addr(input logic [ADDR_SIZE-1:0] a);
    if (!AUTO_INC) return a;
    return (32'(a) == 32'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign op       = bus.din[9:8];
  assign payload  = bus.din[7:0];
  assign accept   = bus.rx_valid & ~rx_valid_q;
  assign wr_ok    = state[0];
  assign rd_ok    = state[1];
  assign in_range = addr_in_range(payload, MEM_DEPTH);

  // One command per cycle, so the single RAM port is either written or read.
  assign we       = accept && (op == CMD_WR_DATA) && wr_ok;
  assign re       = accept && (op == CMD_RD_DATA) && rd_ok;
  assign ram_addr = we ? wr_addr : rd_addr;

  ram_sp #(.DEPTH(MEM_DEPTH), .AW(ADDR_SIZE)) u_ram (
    .clk   (clk),
    .we    (we),
    .re    (re),
    .addr  (ram_addr),
    .wdata (payload),
    .rdata (rdata)
  );

  // RAM read register has no reset; mask it until the first successful read.
  assign bus.dout     = dout_clr ? 8'h00 : rdata;
  assign bus.tx_valid = tx_q;
  assign bus.err      = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      tx_q       <= 1'b0;
      err_q      <= 1'b0;
      dout_clr   <= 1'b1;
    end else begin
      rx_valid_q <= bus.rx_valid;
      err_q      <= 1'b0;
      if (accept) begin
        tx_q <= 1'b0;
        unique case (op)
          CMD_WR_ADDR: begin
            if (in_range) begin
              wr_addr <= payload[ADDR_SIZE-1:0];
              state   <= state_t'(state | ST_WADDR);
            end else err_q <= 1'b1;
          end
          CMD_WR_DATA: begin
            if (wr_ok) wr_addr <= inc_addr(wr_addr);
            else       err_q   <= 1'b1;
          end
          CMD_RD_ADDR: begin
            if (in_range) begin
              rd_addr <= payload[ADDR_SIZE-1:0];
              state   <= state_t'(state | ST_RADDR);
            end else err_q <= 1'b1;
          end
          CMD_RD_DATA: begin
            if (rd_ok) begin
              rd_addr  <= inc_addr(rd_addr);
              tx_q     <= 1'b1;
              dout_clr <= 1'b0;
            end else err_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ram.sv
// Scoreboard bench: stimulus queues expected responses, per-DUT monitors pop and compare.
module tb_spi_cmd_ram;
  import spi_ram_pkg::*;

  typedef struct {
    logic       err;
    logic       tx;
    logic [7:0] dout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_cmd_ram_if bus_a();
  spi_cmd_ram_if bus_b();

  logic [9:0] din_d [2];
  logic       rxv_d [2];
  logic       m_rxv [2];
  logic       m_err [2];
  logic       m_tx  [2];
  logic [7:0] m_dout[2];
  exp_t       q[2][$];

  assign bus_a.din      = din_d[0];
  assign bus_a.rx_valid = rxv_d[0];
  assign bus_b.din      = din_d[1];
  assign bus_b.rx_valid = rxv_d[1];
  assign m_rxv[0] = bus_a.rx_valid;  assign m_rxv[1] = bus_b.rx_valid;
  assign m_err[0] = bus_a.err;       assign m_err[1] = bus_b.err;
  assign m_tx[0]  = bus_a.tx_valid;  assign m_tx[1]  = bus_b.tx_valid;
  assign m_dout[0] = bus_a.dout;     assign m_dout[1] = bus_b.dout;

  // dut_a: non-power-of-two depth with post-increment; dut_b: full 256 words
  spi_cmd_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  spi_cmd_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic chk(input string nm, input int g, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", nm, g, act, want);
    end
  endtask

  function automatic exp_t mk(input logic er, input logic tx, input logic [7:0] d);
    exp_t r;
    r.err = er; r.tx = tx; r.dout = d;
    return r;
  endfunction

  // Monitors: one per DUT, each tracks the expected held tx_valid/dout level
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic       prev = 1'b0;
    logic       pend = 1'b0;
    logic       rst_seen = 1'b0;
    logic       armed = 1'b0;
    logic       ex_tx = 1'b0;
    logic [7:0] ex_dout = 8'h00;
    exp_t       e;

    always @(posedge clk) begin
      pend     <= rst_n && m_rxv[g] && !prev;
      prev     <= rst_n ? m_rxv[g] : 1'b0;
      rst_seen <= !rst_n;
    end

    always @(negedge clk) begin
      if (rst_seen) begin
        armed   = 1'b1;
        ex_tx   = 1'b0;
        ex_dout = 8'h00;
        chk("rst_tx",   g, 8'(m_tx[g]),  8'h00);
        chk("rst_err",  g, 8'(m_err[g]), 8'h00);
        chk("rst_dout", g, m_dout[g],    8'h00);
      end else if (pend) begin
        if (q[g].size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow dut%0d got response want none queued", g);
        end else begin
          e = q[g].pop_front();
          ex_tx = e.tx;
          if (e.tx) ex_dout = e.dout;
          chk("cmd_err",  g, 8'(m_err[g]), 8'(e.err));
          chk("cmd_tx",   g, 8'(m_tx[g]),  8'(ex_tx));
          chk("cmd_dout", g, m_dout[g],    ex_dout);
        end
      end else if (armed) begin
        chk("idle_err",  g, 8'(m_err[g]), 8'h00);
        chk("idle_tx",   g, 8'(m_tx[g]),  8'(ex_tx));
        chk("idle_dout", g, m_dout[g],    ex_dout);
      end
    end
  end

  task automatic cmd(input int d, input logic [9:0] w, input exp_t e, input int hold = 1);
    @(negedge clk);
    din_d[d] = w;
    rxv_d[d] = 1'b1;
    q[d].push_back(e);
    repeat (hold) @(negedge clk);
    rxv_d[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t none_e, err_e;
    none_e = mk(1'b0, 1'b0, 8'h00);
    err_e  = mk(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      din_d[i] = '0;
      rxv_d[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // basic write/read, then tx_valid/dout hold for idle cycles
    cmd(0, 10'h005, none_e);
    cmd(0, 10'h1A5, none_e);
    cmd(0, 10'h205, none_e);
    cmd(0, 10'h300, mk(1'b0, 1'b1, 8'hA5));
    repeat (4) @(negedge clk);
    cmd(0, 10'h000, none_e);
    cmd(0, 10'h13C, none_e);

    // reset while tx_valid is high, then data commands without addresses
    cmd(0, 10'h200, none_e);
    cmd(0, 10'h300, mk(1'b0, 1'b1, 8'h3C));
    pulse_reset();
    cmd(0, 10'h300, err_e);
    cmd(0, 10'h1FF, err_e);
    cmd(0, 10'h200, none_e);
    cmd(0, 10'h300, mk(1'b0, 1'b1, 8'h3C));
    cmd(0, 10'h205, none_e);
    cmd(0, 10'h300, mk(1'b0, 1'b1, 8'hA5));

    // held rx_valid: one write only, no extra address advance
    cmd(0, 10'h00B, none_e);
    cmd(0, 10'h100, none_e);
    cmd(0, 10'h00A, none_e);
    cmd(0, 10'h15A, none_e, 20);
    cmd(0, 10'h20A, none_e);
    cmd(0, 10'h300, mk(1'b0, 1'b1, 8'h5A));
    cmd(0, 10'h300, mk(1'b0, 1'b1, 8'h00));

    // out-of-range address with MEM_DEPTH=200, then top-address wrap
    pulse_reset();
    cmd(0, 10'h0C8, err_e);
    cmd(0, 10'h1EE, err_e);
    cmd(0, 10'h0C7, none_e);
    cmd(0, 10'h1C7, none_e);
    cmd(0, 10'h1D0, none_e);
    cmd(0, 10'h2C7, none_e);
    cmd(0, 10'h300, mk(1'b0, 1'b1, 8'hC7));
    cmd(0, 10'h300, mk(1'b0, 1'b1, 8'hD0));
    cmd(0, 10'h2C8, err_e);

    // 256-word wrap from 0xFF to 0x00
    cmd(1, 10'h0FF, none_e);
    cmd(1, 10'h111, none_e);
    cmd(1, 10'h122, none_e);
    cmd(1, 10'h2FF, none_e);
    cmd(1, 10'h300, mk(1'b0, 1'b1, 8'h11));
    cmd(1, 10'h300, mk(1'b0, 1'b1, 8'h22));

    repeat (5) @(negedge clk);
    chk("sb_leftover", 0, 8'(q[0].size()), 8'h00);
    chk("sb_leftover", 1, 8'(q[1].size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
